// File: rtl/stream_pkt_gen.sv
// AXI-stream packet generator: deterministic byte pattern, programmable length, gap, count,
// periodic error injection and optional LFSR-driven valid throttling.
module stream_pkt_gen #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned CNT_W     = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          start_i,
  input  logic                          stop_i,
  input  logic [LEN_W-1:0]              cfg_len_i,
  input  logic [7:0]                    cfg_gap_i,
  input  logic [CNT_W-1:0]              cfg_num_i,
  input  logic [7:0]                    cfg_err_period_i,
  input  logic                          cfg_bubble_i,
  output logic                          busy_o,
  output logic [CNT_W-1:0]              pkt_cnt_o,
  output logic                          m_axis_valid_o,
  output logic [DATA_W-1:0]             m_axis_data_o,
  output logic [DATA_W/8-1:0]           m_axis_keep_o,
  output logic [$clog2(DATA_W/8)-1:0]   m_axis_vldb_o,
  output logic                          m_axis_sop_o,
  output logic                          m_axis_eop_o,
  output logic                          m_axis_err_o,
  input  logic                          m_axis_ready_i
);

  localparam int unsigned Bytes = DATA_W / 8;
  localparam int unsigned VldbW = $clog2(DATA_W / 8);

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StGap} state_e;

  state_e             state_q;
  logic [LEN_W-1:0]   len_q;
  logic [7:0]         gap_q;
  logic [CNT_W-1:0]   num_q;
  logic [7:0]         errp_q;
  logic               bubble_q;
  logic               stop_q;
  logic [LEN_W-1:0]   rem_q;
  logic [7:0]         byte_q;
  logic [7:0]         ecnt_q;
  logic [7:0]         gcnt_q;
  logic [CNT_W-1:0]   pkt_cnt_q;
  logic [15:0]        lfsr_q;
  logic               hold_q;
  logic               valid_q;
  logic [DATA_W-1:0]  data_q;
  logic [Bytes-1:0]   keep_q;
  logic [VldbW-1:0]   vldb_q;
  logic               sop_q;
  logic               eop_q;
  logic               err_q;

  // Next beat to present; in LOAD it is built from the latched config.
  logic [LEN_W-1:0]   b_rem;
  logic [LEN_W-1:0]   b_nb;
  logic [7:0]         b_byte;
  logic               b_sop;
  logic               b_eop;
  logic               b_err;
  logic [DATA_W-1:0]  b_data;
  logic [Bytes-1:0]   b_keep;
  logic [VldbW-1:0]   b_vldb;
  logic               lfsr_fb;
  logic               accept;
  logic               last_pkt;

  always_comb begin
    b_rem  = rem_q;
    b_byte = byte_q;
    b_sop  = 1'b0;
    if (state_q == StLoad) begin
      b_rem  = (len_q == '0) ? LEN_W'(1) : len_q;
      b_byte = pkt_cnt_q[7:0];
      b_sop  = 1'b1;
    end
    b_eop  = (b_rem <= LEN_W'(Bytes));
    b_nb   = b_eop ? b_rem : LEN_W'(Bytes);
    b_data = '0;
    b_keep = '0;
    for (int unsigned i = 0; i < Bytes; i++) begin
      if (LEN_W'(i) < b_nb) begin
        b_keep[i]         = 1'b1;
        b_data[8*i +: 8]  = b_byte + 8'(i);
      end
    end
    b_vldb = VldbW'(b_nb - LEN_W'(1));
    b_err  = b_eop && (errp_q != 8'd0) && (ecnt_q == errp_q);
  end

  assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign accept   = valid_q && m_axis_ready_i;
  assign last_pkt = (num_q != '0) && ((pkt_cnt_q + CNT_W'(1)) == num_q);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      len_q     <= '0;
      gap_q     <= '0;
      num_q     <= '0;
      errp_q    <= '0;
      bubble_q  <= 1'b0;
      stop_q    <= 1'b0;
      rem_q     <= '0;
      byte_q    <= '0;
      ecnt_q    <= '0;
      gcnt_q    <= '0;
      pkt_cnt_q <= '0;
      lfsr_q    <= LFSR_SEED;
      hold_q    <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      keep_q    <= '0;
      vldb_q    <= '0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
      case (state_q)
        StIdle: begin
          if (start_i && !stop_i) begin
            len_q     <= cfg_len_i;
            gap_q     <= cfg_gap_i;
            num_q     <= cfg_num_i;
            errp_q    <= cfg_err_period_i;
            bubble_q  <= cfg_bubble_i;
            stop_q    <= 1'b0;
            pkt_cnt_q <= '0;
            ecnt_q    <= 8'd1;
            state_q   <= StLoad;
          end
        end
        StLoad: begin
          if (stop_i || stop_q) begin
            state_q <= StIdle;
          end else begin
            valid_q <= 1'b1;
            data_q  <= b_data;
            keep_q  <= b_keep;
            vldb_q  <= b_vldb;
            sop_q   <= b_sop;
            eop_q   <= b_eop;
            err_q   <= b_err;
            rem_q   <= b_rem - LEN_W'(Bytes);
            byte_q  <= b_byte + 8'(Bytes);
            state_q <= StSend;
          end
        end
        StSend: begin
          if (stop_i) begin
            stop_q <= 1'b1;
          end
          if (hold_q && lfsr_q[0]) begin
            hold_q  <= 1'b0;
            valid_q <= 1'b1;
          end
          if (accept) begin
            if (eop_q) begin
              valid_q   <= 1'b0;
              data_q    <= '0;
              keep_q    <= '0;
              vldb_q    <= '0;
              sop_q     <= 1'b0;
              eop_q     <= 1'b0;
              err_q     <= 1'b0;
              pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
              ecnt_q    <= (ecnt_q == errp_q) ? 8'd1 : ecnt_q + 8'd1;
              if (stop_q || stop_i || last_pkt) begin
                state_q <= StIdle;
              end else if (gap_q <= 8'd1) begin
                state_q <= StLoad;
              end else begin
                // LOAD supplies the final idle cycle of the gap.
                gcnt_q  <= gap_q - 8'd1;
                state_q <= StGap;
              end
            end else begin
              data_q <= b_data;
              keep_q <= b_keep;
              vldb_q <= b_vldb;
              sop_q  <= b_sop;
              eop_q  <= b_eop;
              err_q  <= b_err;
              rem_q  <= rem_q - LEN_W'(Bytes);
              byte_q <= byte_q + 8'(Bytes);
              if (bubble_q && !lfsr_q[0]) begin
                valid_q <= 1'b0;
                hold_q  <= 1'b1;
              end else begin
                valid_q <= 1'b1;
              end
            end
          end
        end
        StGap: begin
          if (stop_i || stop_q) begin
            state_q <= StIdle;
          end else if (gcnt_q <= 8'd1) begin
            state_q <= StLoad;
          end else begin
            gcnt_q <= gcnt_q - 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o         = (state_q != StIdle);
  assign pkt_cnt_o      = pkt_cnt_q;
  assign m_axis_valid_o = valid_q;
  assign m_axis_data_o  = data_q;
  assign m_axis_keep_o  = keep_q;
  assign m_axis_vldb_o  = vldb_q;
  assign m_axis_sop_o   = sop_q;
  assign m_axis_eop_o   = eop_q;
  assign m_axis_err_o   = err_q;

endmodule

// File: tb/tb_stream_pkt_gen.sv
// Directed bench for stream_pkt_gen: table of packet runs checked beat by beat against a
// byte-pattern model, plus hand sequences for latency, stop/start corners and reset.
module tb_stream_pkt_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [15:0] cfg_len;
  logic [7:0]  cfg_gap;
  logic [31:0] cfg_num;
  logic [7:0]  cfg_errp;
  logic        cfg_bub;
  logic        busy;
  logic [31:0] pkt_cnt;
  logic        valid;
  logic [63:0] data;
  logic [7:0]  keep;
  logic [2:0]  vldb;
  logic        sop;
  logic        eop;
  logic        err;
  logic        ready;

  int nvec = 0;
  int nerr = 0;

  stream_pkt_gen dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .start_i          (start),
    .stop_i           (stop),
    .cfg_len_i        (cfg_len),
    .cfg_gap_i        (cfg_gap),
    .cfg_num_i        (cfg_num),
    .cfg_err_period_i (cfg_errp),
    .cfg_bubble_i     (cfg_bub),
    .busy_o           (busy),
    .pkt_cnt_o        (pkt_cnt),
    .m_axis_valid_o   (valid),
    .m_axis_data_o    (data),
    .m_axis_keep_o    (keep),
    .m_axis_vldb_o    (vldb),
    .m_axis_sop_o     (sop),
    .m_axis_eop_o     (eop),
    .m_axis_err_o     (err),
    .m_axis_ready_i   (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] len;
    logic [7:0]  gap;
    logic [31:0] num;
    logic [7:0]  errp;
    logic        bub;
    logic        rnd;
    int          stop_pkt;
    int          beats;
    logic [7:0]  lkeep;
    logic [2:0]  lvldb;
    int          cnt;
  } case_t;

  case_t tbl [9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] outs_all();
    return 128'({valid, busy, sop, eop, err, pkt_cnt, data, keep, vldb});
  endfunction

  task automatic run_case(input case_t c, input int id);
    int pidx, k, rem, nb, beats, idle, gaps, cyc, tot;
    logic in_gap, in_pkt, stall, errb;
    logic [77:0] prev, cur, expv;
    logic [63:0] ed;
    logic [7:0]  ek;
    pidx = 0; k = 0; beats = 0; idle = 0; gaps = 0;
    in_gap = 1'b0; in_pkt = 1'b0; stall = 1'b0; prev = '0;
    tot = (c.len == 16'd0) ? 1 : int'(c.len);
    cfg_len = c.len; cfg_gap = c.gap; cfg_num = c.num; cfg_errp = c.errp; cfg_bub = c.bub;
    start = 1'b1;
    @(negedge clk);
    // DUT is in LOAD: a second start with different config must be ignored.
    cfg_len = 16'd5; cfg_gap = 8'd9; cfg_num = 32'd7; cfg_errp = 8'd1; cfg_bub = ~c.bub;
    chk($sformatf("c%0d_load_state", id), 128'({busy, valid}), 128'(2'b10));
    @(negedge clk);
    start = 1'b0;
    for (cyc = 0; cyc < 20000 && busy; cyc++) begin
      stop  = 1'b0;
      ready = c.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cur   = {data, keep, vldb, sop, eop, err};
      if (stall) chk($sformatf("c%0d_hold", id), 128'({valid, cur}), 128'({1'b1, prev}));
      if (valid) begin
        if (in_gap) begin
          chk($sformatf("c%0d_gap", id), 128'(idle), 128'((c.gap > 8'd1) ? int'(c.gap) : 1));
          in_gap = 1'b0;
        end
        if (ready) begin
          rem = tot - k;
          nb  = (rem > 8) ? 8 : rem;
          ek  = '0;
          ed  = '0;
          for (int i = 0; i < nb; i++) begin
            ek[i]        = 1'b1;
            ed[i*8 +: 8] = 8'(pidx + k + i);
          end
          errb = (rem <= 8) && (c.errp != 8'd0) && (((pidx + 1) % int'(c.errp)) == 0);
          expv = {ed, ek, 3'(nb - 1), (k == 0), (rem <= 8), errb};
          chk($sformatf("c%0d_p%0d_b%0d", id, pidx, beats), 128'(cur), 128'(expv));
          if (c.stop_pkt == pidx && k == 0) stop = 1'b1;
          k += 8;
          beats++;
          in_pkt = 1'b1;
          if (rem <= 8) begin
            chk($sformatf("c%0d_p%0d_shape", id, pidx), 128'({beats, keep, vldb}),
                128'({c.beats, c.lkeep, c.lvldb}));
            pidx++;
            k = 0; beats = 0; idle = 0;
            in_gap = 1'b1; in_pkt = 1'b0;
          end
        end
      end else begin
        if (in_gap) idle++;
        else if (in_pkt) gaps++;
      end
      stall = valid && !ready;
      prev  = cur;
      @(negedge clk);
    end
    stop = 1'b0;
    chk($sformatf("c%0d_finished", id), 128'(busy), 128'(1'b0));
    chk($sformatf("c%0d_count", id), 128'({pidx, pkt_cnt}), 128'({c.cnt, c.cnt}));
    chk($sformatf("c%0d_bubbles", id), 128'(gaps > 0), 128'(c.bub));
    repeat (3) @(negedge clk);
    chk($sformatf("c%0d_cnt_hold", id), 128'({busy, valid, pkt_cnt}), 128'({2'b00, c.cnt}));
  endtask

  initial begin
    tbl[0] = '{16'd64,  8'd0, 32'd1,   8'd0, 1'b0, 1'b0, -1, 8,  8'hFF, 3'd7, 1};
    tbl[1] = '{16'd13,  8'd4, 32'd3,   8'd0, 1'b0, 1'b0, -1, 2,  8'h1F, 3'd4, 3};
    tbl[2] = '{16'd100, 8'd1, 32'd2,   8'd0, 1'b0, 1'b1, -1, 13, 8'h0F, 3'd3, 2};
    tbl[3] = '{16'd20,  8'd2, 32'd6,   8'd3, 1'b0, 1'b0, -1, 3,  8'h0F, 3'd3, 6};
    tbl[4] = '{16'd40,  8'd0, 32'd0,   8'd0, 1'b1, 1'b0, 4,  5,  8'hFF, 3'd7, 5};
    tbl[5] = '{16'd0,   8'd0, 32'd2,   8'd0, 1'b0, 1'b1, -1, 1,  8'h01, 3'd0, 2};
    tbl[6] = '{16'd8,   8'd3, 32'd2,   8'd1, 1'b0, 1'b0, -1, 1,  8'hFF, 3'd7, 2};
    tbl[7] = '{16'd9,   8'd0, 32'd1,   8'd0, 1'b0, 1'b1, -1, 2,  8'h01, 3'd0, 1};
    tbl[8] = '{16'd1,   8'd0, 32'd300, 8'd7, 1'b0, 1'b0, -1, 1,  8'h01, 3'd0, 300};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; ready = 1'b0;
    cfg_len = '0; cfg_gap = '0; cfg_num = '0; cfg_errp = '0; cfg_bub = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", outs_all(), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 9; t++) run_case(tbl[t], t);

    // Start latency, counter clear and first/last beat contents.
    cfg_len = 16'd16; cfg_gap = 8'd0; cfg_num = 32'd1; cfg_errp = 8'd0; cfg_bub = 1'b0;
    ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("lat_load", 128'({busy, valid, pkt_cnt}), 128'({2'b10, 32'd0}));
    @(negedge clk);
    chk("lat_first", 128'({valid, sop, eop, keep, data}),
        128'({3'b110, 8'hFF, 64'h0706050403020100}));
    @(negedge clk);
    chk("lat_second", 128'({valid, sop, eop, keep, data}),
        128'({3'b101, 8'hFF, 64'h0F0E0D0C0B0A0908}));
    @(negedge clk);
    chk("lat_done", 128'({busy, valid, pkt_cnt}), 128'({2'b00, 32'd1}));

    // Start and stop together in IDLE: stop wins.
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", 128'({busy, valid}), 128'(2'b00));
    @(negedge clk);
    chk("start_stop_idle2", 128'({busy, valid, pkt_cnt}), 128'({2'b00, 32'd1}));

    // Stop during LOAD: back to IDLE without presenting a beat.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_in_load", 128'({busy, valid, pkt_cnt}), 128'({2'b00, 32'd0}));
    @(negedge clk);
    chk("stop_in_load2", 128'({busy, valid}), 128'(2'b00));

    // Reset while a beat is held by backpressure.
    cfg_len = 16'd64; cfg_num = 32'd1; ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("held_before_reset", 128'({valid, sop, data}), 128'({2'b11, 64'h0706050403020100}));
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_beat", outs_all(), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_case(tbl[0], 9);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
